// File: rtl/vga_out_pkg.sv
// Shared constants for the VGA output stage: mode encodings and delay-word layout.
package vga_out_pkg;

  // Output modes selected through i_mode
  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_GATE   = 2'd1;
  localparam logic [1:0] MODE_SOLID  = 2'd2;
  localparam logic [1:0] MODE_INVERT = 2'd3;

  // Delay word = {rgb, hsync_n, vsync_n, hblank, vblank}
  localparam int unsigned RGB_BITS_DEF = 6;
  localparam int unsigned VGA_CTRL_W   = 4;
  localparam int unsigned VGA_WORD_W   = RGB_BITS_DEF + VGA_CTRL_W;

  // Idle control bits: syncs deasserted (high), blanking asserted
  localparam logic [VGA_CTRL_W-1:0] VGA_CTRL_RST = 4'b1111;
  localparam logic [VGA_WORD_W-1:0] VGA_WORD_RST = {RGB_BITS_DEF'(0), VGA_CTRL_RST};

  // Word width for a non-default colour bus
  function automatic int unsigned vga_word_w(input int unsigned rgb_bits);
    return rgb_bits + VGA_CTRL_W;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register of video words with a runtime tap select (tap 0 = input).
module vga_delay_line #(
  parameter int unsigned     W        = 10,
  parameter int unsigned     DEPTH    = 3,
  parameter logic [W-1:0]    RST_WORD = '0,
  localparam int unsigned    SW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  i_word,
  input  logic [SW-1:0] i_sel,
  output logic [W-1:0]  o_word
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  // Next-state: every stage takes the one before it
  always_comb begin
    stage_d[0] = i_word;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Stage registers, reset to the idle word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_q[k] <= RST_WORD;
      end
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // Tap mux: select 0 bypasses, select k returns stage k
  always_comb begin
    o_word = i_word;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (i_sel == SW'(k)) begin
        o_word = stage_q[k-1];
      end
    end
  end

endmodule

// File: rtl/vga_output_pipe.sv
// VGA output stage: colour mode front-end, aligned delay line, vsync-latched config, frame counter.
module vga_output_pipe
  import vga_out_pkg::*;
#(
  parameter int unsigned  RGB_BITS   = 6,
  parameter int unsigned  DELAY_MAX  = 3,
  parameter int unsigned  FRAME_BITS = 8,
  localparam int unsigned DW         = $clog2(DELAY_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [RGB_BITS-1:0]   i_rgb,
  input  logic                  i_hsync_n,
  input  logic                  i_vsync_n,
  input  logic                  i_hblank,
  input  logic                  i_vblank,
  input  logic [DW-1:0]         i_delay,
  input  logic [1:0]            i_mode,
  input  logic [RGB_BITS-1:0]   i_solid_rgb,
  output logic [RGB_BITS-1:0]   o_rgb,
  output logic                  o_hsync_n,
  output logic                  o_vsync_n,
  output logic                  o_hblank,
  output logic                  o_vblank,
  output logic [FRAME_BITS-1:0] o_frame,
  output logic                  o_cfg_pending
);

  localparam int unsigned      WW       = vga_word_w(RGB_BITS);
  localparam logic [WW-1:0]    WORD_RST = {RGB_BITS'(0), VGA_CTRL_RST};

  logic                  vsync_prev_q, vsync_prev_d;
  logic [DW-1:0]         delay_q, delay_d;
  logic [1:0]            mode_q, mode_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;

  logic                  vsync_start_c;
  logic [DW-1:0]         delay_req_c;
  logic                  blank_c;
  logic [RGB_BITS-1:0]   fe_rgb_c;
  logic [WW-1:0]         fe_word_c;
  logic [WW-1:0]         tap_word_c;

  // Requested depth, clamped to the deepest implemented stage
  always_comb begin
    delay_req_c = i_delay;
    if (32'(i_delay) > DELAY_MAX) begin
      delay_req_c = DW'(DELAY_MAX);
    end
  end

  // Falling edge of vsync latches the requested config and counts the frame
  always_comb begin
    vsync_prev_d  = i_vsync_n;
    delay_d       = delay_q;
    mode_d        = mode_q;
    frame_d       = frame_q;
    vsync_start_c = !i_vsync_n && vsync_prev_q;
    if (vsync_start_c) begin
      delay_d = delay_req_c;
      mode_d  = i_mode;
      frame_d = frame_q + FRAME_BITS'(1);
    end
  end

  // Shadow config, vsync edge detector and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_q <= 1'b1;
      delay_q      <= '0;
      mode_q       <= MODE_PASS;
      frame_q      <= '0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      delay_q      <= delay_d;
      mode_q       <= mode_d;
      frame_q      <= frame_d;
    end
  end

  // Colour front-end under the active mode; syncs and blanks pass untouched
  always_comb begin
    blank_c  = i_hblank | i_vblank;
    fe_rgb_c = i_rgb;
    case (mode_q)
      MODE_PASS:   fe_rgb_c = i_rgb;
      MODE_GATE:   fe_rgb_c = blank_c ? '0 : i_rgb;
      MODE_SOLID:  fe_rgb_c = blank_c ? '0 : i_solid_rgb;
      MODE_INVERT: fe_rgb_c = blank_c ? '0 : ~i_rgb;
    endcase
    fe_word_c = {fe_rgb_c, i_hsync_n, i_vsync_n, i_hblank, i_vblank};
  end

  vga_delay_line #(
    .W        (WW),
    .DEPTH    (DELAY_MAX),
    .RST_WORD (WORD_RST)
  ) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_word (fe_word_c),
    .i_sel  (delay_q),
    .o_word (tap_word_c)
  );

  assign {o_rgb, o_hsync_n, o_vsync_n, o_hblank, o_vblank} = tap_word_c;
  assign o_frame       = frame_q;
  assign o_cfg_pending = (delay_req_c != delay_q) || (i_mode != mode_q);

endmodule

// File: tb/tb_vga_output_pipe.sv
// Directed bench for vga_output_pipe with a latency-aware scoreboard of output words.
module tb_vga_output_pipe;

  localparam int unsigned RGB_BITS   = 6;
  localparam int unsigned DELAY_MAX  = 3;
  localparam int unsigned FRAME_BITS = 8;
  localparam int unsigned DW         = $clog2(DELAY_MAX + 1);
  localparam int unsigned WW         = RGB_BITS + 4;

  logic                  clk;
  logic                  rst_n;
  logic [RGB_BITS-1:0]   i_rgb;
  logic                  i_hsync_n, i_vsync_n, i_hblank, i_vblank;
  logic [DW-1:0]         i_delay;
  logic [1:0]            i_mode;
  logic [RGB_BITS-1:0]   i_solid_rgb;
  logic [RGB_BITS-1:0]   o_rgb;
  logic                  o_hsync_n, o_vsync_n, o_hblank, o_vblank;
  logic [FRAME_BITS-1:0] o_frame;
  logic                  o_cfg_pending;
  logic [WW-1:0]         out_word;

  vga_output_pipe #(
    .RGB_BITS   (RGB_BITS),
    .DELAY_MAX  (DELAY_MAX),
    .FRAME_BITS (FRAME_BITS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rgb         (i_rgb),
    .i_hsync_n     (i_hsync_n),
    .i_vsync_n     (i_vsync_n),
    .i_hblank      (i_hblank),
    .i_vblank      (i_vblank),
    .i_delay       (i_delay),
    .i_mode        (i_mode),
    .i_solid_rgb   (i_solid_rgb),
    .o_rgb         (o_rgb),
    .o_hsync_n     (o_hsync_n),
    .o_vsync_n     (o_vsync_n),
    .o_hblank      (o_hblank),
    .o_vblank      (o_vblank),
    .o_frame       (o_frame),
    .o_cfg_pending (o_cfg_pending)
  );

  assign out_word = {o_rgb, o_hsync_n, o_vsync_n, o_hblank, o_vblank};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    int            due;
    logic [WW-1:0] word;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  // Reference model of the active configuration
  int unsigned           m_lat;
  logic [1:0]            m_mode;
  logic [FRAME_BITS-1:0] m_frame;
  logic                  m_prev_vs;
  logic [FRAME_BITS-1:0] f_before;

  function automatic logic [RGB_BITS-1:0] fe_model(input logic [1:0] m, input logic [RGB_BITS-1:0] rgb,
                                                    input logic [RGB_BITS-1:0] solid, input logic blank);
    case (m)
      2'd0:    return rgb;
      2'd1:    return blank ? '0 : rgb;
      2'd2:    return blank ? '0 : solid;
      default: return blank ? '0 : ~rgb;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lat     = 0;
    m_mode    = 2'd0;
    m_frame   = '0;
    m_prev_vs = 1'b1;
  endtask

  // Advance one clock; update the model from the inputs held during the cycle just ended
  task automatic tick();
    bit start;
    start = rst_n && !i_vsync_n && m_prev_vs;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (start) begin
        m_mode  = i_mode;
        m_lat   = (int'(i_delay) > DELAY_MAX) ? DELAY_MAX : int'(i_delay);
        m_frame = m_frame + 1'b1;
      end
      m_prev_vs = i_vsync_n;
    end
  endtask

  task automatic drive(input logic [RGB_BITS-1:0] rgb, input logic hs, input logic vs,
                       input logic hb, input logic vb);
    i_rgb     = rgb;
    i_hsync_n = hs;
    i_vsync_n = vs;
    i_hblank  = hb;
    i_vblank  = vb;
  endtask

  // Push the word the current inputs should produce after the active latency
  task automatic expect_out(input string tag);
    exp_t e;
    e.tag  = tag;
    e.due  = cyc + int'(m_lat);
    e.word = {fe_model(m_mode, i_rgb, i_solid_rgb, i_hblank | i_vblank),
              i_hsync_n, i_vsync_n, i_hblank, i_vblank};
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then retire every entry due this cycle
  task automatic settle();
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, 32'(out_word), 32'(sb[i].word));
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        checks++;
        errors++;
        $error("FAIL %s: observed none expected %0h at cycle %0d", sb[i].tag, sb[i].word, sb[i].due);
        sb.delete(i);
      end
    end
  endtask

  task automatic step(input string tag, input logic [RGB_BITS-1:0] rgb, input logic hs,
                      input logic vs, input logic hb, input logic vb, input bit push);
    tick();
    drive(rgb, hs, vs, hb, vb);
    if (push) expect_out(tag);
    settle();
  endtask

  task automatic vsync_pulse();
    step("vs_lo", '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("vs_hi", '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // Idle line words around a single-cycle 3F pulse with hsync asserted
  task automatic pulse_test(input string tag);
    for (int i = 0; i < 3; i++) step({tag, "_pre"}, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step({tag, "_pulse"}, 6'h3F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step({tag, "_post"}, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    model_reset();
    rst_n       = 1'b0;
    i_delay     = '0;
    i_mode      = 2'd0;
    i_solid_rgb = '0;
    drive('0, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;

    // Reset state: delay 0 PASS passes inputs straight through
    drive(6'h2A, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check("rst_rgb_comb", 32'(o_rgb), 32'h2A);
    check("rst_frame", 32'(o_frame), 32'h0);
    check("rst_pending", 32'(o_cfg_pending), 32'h0);
    i_hsync_n = 1'b0;
    #1;
    check("rst_hsync_comb", 32'(o_hsync_n), 32'h0);

    tick();
    rst_n = 1'b1;
    drive(6'h2A, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("d0_pass");
    settle();
    step("d0_line", 6'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Mid-frame request for depth 2: pending, latency unchanged
    i_delay = DW'(2);
    step("d0_hold", 6'h15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("d2_pending_mid", 32'(o_cfg_pending), 32'h1);
    check("d0_hold_rgb", 32'(o_rgb), 32'h15);
    vsync_pulse();
    check("d2_pending_clr", 32'(o_cfg_pending), 32'h0);
    check("d2_frame", 32'(o_frame), 32'(m_frame));
    pulse_test("d2");

    // Out-of-range request clamps to the deepest stage
    i_delay = DW'(7);
    vsync_pulse();
    check("d3_pending_clr", 32'(o_cfg_pending), 32'h0);
    pulse_test("d3");

    // Reset mid-line with depth 3 returns to bypass and idle state at once
    for (int i = 0; i < 3; i++) step("line", 6'h15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive('0, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mrst_rgb", 32'(o_rgb), 32'h0);
    check("mrst_hsync", 32'(o_hsync_n), 32'h1);
    check("mrst_frame", 32'(o_frame), 32'h0);
    check("mrst_pending", 32'(o_cfg_pending), 32'h1);
    i_rgb = 6'h2A;
    #1;
    check("mrst_delay0", 32'(o_rgb), 32'h2A);
    tick();
    rst_n   = 1'b1;
    i_delay = '0;
    drive('0, 1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    check("mrst_release_pending", 32'(o_cfg_pending), 32'h0);

    // GATE requested but not yet active: still PASS
    i_mode = 2'd1;
    step("gate_prewait", 6'h3F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("gate_pending", 32'(o_cfg_pending), 32'h1);
    check("gate_prewait_rgb", 32'(o_rgb), 32'h3F);
    vsync_pulse();
    check("frame_after_rst", 32'(o_frame), 32'h1);
    step("gate_hblank", 6'h3F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("gate_hblank_rgb", 32'(o_rgb), 32'h0);
    step("gate_active", 6'h3F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("gate_vblank", 6'h3F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

    // SOLID
    i_mode      = 2'd2;
    i_solid_rgb = 6'h30;
    vsync_pulse();
    step("solid_active", 6'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("solid_active_rgb", 32'(o_rgb), 32'h30);
    step("solid_hblank", 6'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // INVERT
    i_mode = 2'd3;
    vsync_pulse();
    step("inv_active", 6'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("inv_active_rgb", 32'(o_rgb), 32'h30);
    step("inv_vblank", 6'h0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    i_mode = 2'd0;
    vsync_pulse();

    // 257 frames wrap the 8-bit counter to one past its start
    f_before = o_frame;
    for (int i = 0; i < 257; i++) vsync_pulse();
    check("frame_wrap", 32'(o_frame), 32'(m_frame));
    check("frame_wrap_delta", 32'(o_frame), 32'(FRAME_BITS'(f_before + 1'b1)));

    // vsync held low counts once
    f_before = o_frame;
    for (int i = 0; i < 100; i++) step("vs_held", '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("vs_rel", '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("vs_held_once", 32'(o_frame), 32'(FRAME_BITS'(f_before + 1'b1)));
    check("vs_held_model", 32'(o_frame), 32'(m_frame));

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d expected 0 outstanding", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
